// File: rtl/redmule_job_monitor.sv
// rtl/redmule_job_monitor.sv - job launch/complete monitor for the RedMulE accelerator wrapper
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            single-cycle job launch request (honoured only in IDLE)
//   evt_i              per-core event lines; bit 0 of any lane marks job completion
//   busy_i             accelerator busy flag
//   irq_ack_i          host acknowledge of the completion interrupt
//   clear_i            synchronous abort/clear, highest priority
//   fetch_enable_o     accelerator fetch enable, high in ARM and RUN
//   irq_o              job-complete interrupt (level, DONE)
//   err_o              arm timeout flag (level, ERR)
//   busy_cycles_o      saturating busy-cycle count of the current/last job
//   job_count_o        number of acknowledged jobs, wraps modulo 2^16
module redmule_job_monitor #(
    parameter int N_CORES     = 8,
    parameter int CNT_W       = 32,
    parameter int ARM_TIMEOUT = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [N_CORES-1:0][1:0] evt_i,
    input  logic                    busy_i,
    input  logic                    irq_ack_i,
    input  logic                    clear_i,
    output logic                    fetch_enable_o,
    output logic                    irq_o,
    output logic                    err_o,
    output logic [CNT_W-1:0]        busy_cycles_o,
    output logic [15:0]             job_count_o
);

    // The arm counter never needs to exceed ARM_TIMEOUT-1.
    localparam int ArmW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [ArmW-1:0] ArmLast = ArmW'(ARM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ArmW-1:0]   arm_cnt_q, arm_cnt_d;
    logic [CNT_W-1:0]  busy_cycles_q, busy_cycles_d;
    logic [15:0]       job_count_q, job_count_d;
    logic              fetch_enable_q, fetch_enable_d;
    logic              irq_q, irq_d;
    logic              err_q, err_d;

    logic done_evt;
    logic unused_evt_hi;

    always_comb begin
        done_evt      = 1'b0;
        unused_evt_hi = 1'b0;
        for (int c = 0; c < N_CORES; c++) begin
            done_evt      = done_evt | evt_i[c][0];
            unused_evt_hi = unused_evt_hi ^ evt_i[c][1];
        end
    end

    always_comb begin
        state_d       = state_q;
        arm_cnt_d     = arm_cnt_q;
        busy_cycles_d = busy_cycles_q;
        job_count_d   = job_count_q;

        if (clear_i) begin
            state_d       = IDLE;
            arm_cnt_d     = '0;
            busy_cycles_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d       = ARM;
                        arm_cnt_d     = '0;
                        busy_cycles_d = '0;
                    end
                end
                ARM: begin
                    arm_cnt_d = arm_cnt_q + ArmW'(1);
                    // busy_i beats a coincident timeout. The cycle that
                    // moves ARM to RUN is the first busy cycle of the job.
                    if (busy_i) begin
                        state_d       = RUN;
                        busy_cycles_d = busy_cycles_q + CNT_W'(1);
                    end else if (arm_cnt_q == ArmLast) begin
                        state_d = ERR;
                    end
                end
                RUN: begin
                    if (busy_i && (busy_cycles_q != CntMax)) begin
                        busy_cycles_d = busy_cycles_q + CNT_W'(1);
                    end
                    if (done_evt) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (irq_ack_i) begin
                        state_d     = IDLE;
                        job_count_d = job_count_q + 16'd1;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs come from the next state so they are plain flop outputs
        // that change together with the state register.
        fetch_enable_d = (state_d == ARM) || (state_d == RUN);
        irq_d          = (state_d == DONE);
        err_d          = (state_d == ERR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            arm_cnt_q      <= '0;
            busy_cycles_q  <= '0;
            job_count_q    <= '0;
            fetch_enable_q <= 1'b0;
            irq_q          <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            arm_cnt_q      <= arm_cnt_d;
            busy_cycles_q  <= busy_cycles_d;
            job_count_q    <= job_count_d;
            fetch_enable_q <= fetch_enable_d;
            irq_q          <= irq_d;
            err_q          <= err_d;
        end
    end

    assign fetch_enable_o = fetch_enable_q;
    assign irq_o          = irq_q;
    assign err_o          = err_q;
    assign busy_cycles_o  = busy_cycles_q;
    assign job_count_o    = job_count_q;

endmodule

// File: tb/tb_redmule_job_monitor.sv
// tb/tb_redmule_job_monitor.sv - self-checking bench for redmule_job_monitor
module tb_redmule_job_monitor;

    localparam int NC  = 8;
    localparam int CW  = 4;
    localparam int TMO = 4;
    localparam int SAT = (1 << CW) - 1;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               start_i = 1'b0;
    logic [NC-1:0][1:0] evt_i = '0;
    logic               busy_i = 1'b0;
    logic               irq_ack_i = 1'b0;
    logic               clear_i = 1'b0;
    logic               fetch_enable_o;
    logic               irq_o;
    logic               err_o;
    logic [CW-1:0]      busy_cycles_o;
    logic [15:0]        job_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    redmule_job_monitor #(
        .N_CORES     (NC),
        .CNT_W       (CW),
        .ARM_TIMEOUT (TMO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .evt_i          (evt_i),
        .busy_i         (busy_i),
        .irq_ack_i      (irq_ack_i),
        .clear_i        (clear_i),
        .fetch_enable_o (fetch_enable_o),
        .irq_o          (irq_o),
        .err_o          (err_o),
        .busy_cycles_o  (busy_cycles_o),
        .job_count_o    (job_count_o)
    );

    // Reference model: job phase, cycles waited for busy, busy count, jobs.
    localparam int PH_IDLE = 0, PH_WAIT_BUSY = 1, PH_WORK = 2, PH_FINISHED = 3, PH_FAULT = 4;
    int m_phase = PH_IDLE;
    int m_waited = 0;
    int m_busy = 0;
    int m_job = 0;

    task automatic model_reset();
        m_phase = PH_IDLE; m_waited = 0; m_busy = 0; m_job = 0;
    endtask

    task automatic model_step();
        bit done_seen;
        done_seen = 0;
        for (int c = 0; c < NC; c++) done_seen |= evt_i[c][0];
        if (clear_i) begin
            m_phase = PH_IDLE; m_busy = 0;
        end else if (m_phase == PH_IDLE) begin
            if (start_i) begin m_phase = PH_WAIT_BUSY; m_waited = 0; m_busy = 0; end
        end else if (m_phase == PH_WAIT_BUSY) begin
            if (busy_i) begin m_phase = PH_WORK; m_busy = 1; end
            else if (m_waited == TMO - 1) m_phase = PH_FAULT;
            else m_waited++;
        end else if (m_phase == PH_WORK) begin
            if (busy_i && m_busy < SAT) m_busy++;
            if (done_seen) m_phase = PH_FINISHED;
        end else if (m_phase == PH_FINISHED) begin
            if (irq_ack_i) begin m_phase = PH_IDLE; m_job = (m_job + 1) % 65536; end
        end
    endtask

    function automatic logic [22:0] dut_vec();
        return {fetch_enable_o, irq_o, err_o, busy_cycles_o, job_count_o};
    endfunction

    function automatic logic [22:0] mdl_vec();
        return {(m_phase == PH_WAIT_BUSY) || (m_phase == PH_WORK), m_phase == PH_FINISHED,
                m_phase == PH_FAULT, 4'(m_busy), 16'(m_job)};
    endfunction

    // Apply inputs, advance one clock for DUT and model, sample 1 ns later.
    task automatic step(input logic s, input logic [NC-1:0][1:0] e, input logic b,
                        input logic a, input logic c);
        start_i = s; evt_i = e; busy_i = b; irq_ack_i = a; clear_i = c;
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    function automatic logic [NC-1:0][1:0] lane(input int idx, input int bitn);
        logic [NC-1:0][1:0] v;
        v = '0;
        v[idx][bitn] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(0, '0, 0, 0, 0);
        if (dut_vec() !== 23'd0) begin
            $display("FAIL reset outputs got %h exp %h", dut_vec(), 23'd0); errors++;
        end
        checks++;
    endtask

    task automatic test_nominal();
        step(1, '0, 0, 0, 0);
        if (fetch_enable_o !== 1'b1) begin
            $display("FAIL nominal_first_arm fe got %b exp 1", fetch_enable_o); errors++;
        end
        checks++;
        for (int i = 0; i < 3 + 10 + 3; i++) begin
            if (i < 3) step(0, '0, 0, 0, 0);
            else if (i < 13) step(0, (i == 12) ? lane(2, 0) : '0, 1, 0, 0);
            else step(0, '0, 0, 0, 0);
            if (dut_vec() !== mdl_vec()) begin
                $display("FAIL nominal cyc %0d got %h exp %h", i, dut_vec(), mdl_vec()); errors++;
            end
            checks++;
        end
        if (busy_cycles_o !== 4'd10 || irq_o !== 1'b1 || fetch_enable_o !== 1'b0) begin
            $display("FAIL nominal_done busy %0d irq %b fe %b exp 10 1 0",
                     busy_cycles_o, irq_o, fetch_enable_o); errors++;
        end
        checks++;
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 0, 0);
        if (job_count_o !== 16'd1 || irq_o !== 1'b0 || busy_cycles_o !== 4'd10) begin
            $display("FAIL nominal_ack job %0d irq %b busy %0d exp 1 0 10",
                     job_count_o, irq_o, busy_cycles_o); errors++;
        end
        checks++;
    endtask

    task automatic test_timeout();
        logic [15:0] job_before;
        job_before = job_count_o;
        step(1, '0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(i == 2, '0, 0, 0, 0);
            if (dut_vec() !== mdl_vec()) begin
                $display("FAIL timeout cyc %0d got %h exp %h", i, dut_vec(), mdl_vec()); errors++;
            end
            checks++;
        end
        if (err_o !== 1'b1 || fetch_enable_o !== 1'b0) begin
            $display("FAIL timeout_err err %b fe %b exp 1 0", err_o, fetch_enable_o); errors++;
        end
        checks++;
        step(0, '0, 0, 0, 1);
        if (err_o !== 1'b0 || job_count_o !== job_before || dut_vec() !== mdl_vec()) begin
            $display("FAIL timeout_clear err %b job %0d exp 0 %0d", err_o, job_count_o, job_before);
            errors++;
        end
        checks++;
    endtask

    task automatic test_ignored_events();
        for (int i = 0; i < 12; i++) begin
            if (i < 2) step(0, lane(0, 0), 0, 0, 0);
            else if (i == 2) step(1, '0, 0, 0, 0);
            else if (i == 3) step(0, '0, 1, 0, 0);
            else if (i < 7) step(0, lane(5, 1), 1, 0, 0);
            else step(i == 8, lane(5, 1), 0, 0, 0);
            if (dut_vec() !== mdl_vec() || irq_o !== 1'b0) begin
                $display("FAIL ignored cyc %0d got %h exp %h", i, dut_vec(), mdl_vec()); errors++;
            end
            checks++;
        end
        if (busy_cycles_o !== 4'd4 || fetch_enable_o !== 1'b1) begin
            $display("FAIL ignored_busy_drop busy %0d fe %b exp 4 1", busy_cycles_o, fetch_enable_o);
            errors++;
        end
        checks++;
        step(0, lane(1, 0), 0, 0, 0);
        step(0, '0, 0, 1, 0);
    endtask

    task automatic test_saturation();
        step(1, '0, 0, 0, 0);
        for (int i = 0; i < 21; i++) begin
            step(0, (i == 20) ? lane(7, 0) : '0, 1, 0, 0);
            if (dut_vec() !== mdl_vec()) begin
                $display("FAIL saturate cyc %0d got %h exp %h", i, dut_vec(), mdl_vec()); errors++;
            end
            checks++;
        end
        if (busy_cycles_o !== 4'd15) begin
            $display("FAIL saturate_final busy %0d exp 15", busy_cycles_o); errors++;
        end
        checks++;
    endtask

    task automatic test_simultaneous();
        logic [15:0] job_before;
        job_before = job_count_o;
        step(1, '0, 0, 1, 0);
        step(0, '0, 0, 0, 0);
        if (job_count_o !== job_before + 16'd1 || fetch_enable_o !== 1'b0 || irq_o !== 1'b0) begin
            $display("FAIL start_ack job %0d fe %b irq %b exp %0d 0 0",
                     job_count_o, fetch_enable_o, irq_o, job_before + 16'd1); errors++;
        end
        checks++;
        step(1, '0, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, lane(3, 0), 1, 0, 1);
        if (dut_vec() !== mdl_vec() || irq_o !== 1'b0 || busy_cycles_o !== 4'd0) begin
            $display("FAIL clear_vs_done got %h exp %h", dut_vec(), mdl_vec()); errors++;
        end
        checks++;
    endtask

    task automatic test_async_reset();
        step(1, '0, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        #3;
        rst_ni = 1'b0;
        #1;
        if ({fetch_enable_o, irq_o, err_o, busy_cycles_o, job_count_o} !== 23'd0) begin
            $display("FAIL async_reset got %h exp 0", dut_vec()); errors++;
        end
        checks++;
        model_reset();
        busy_i = 1'b0;
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        step(0, lane(2, 0), 0, 1, 0);
        if (dut_vec() !== 23'd0) begin
            $display("FAIL post_reset got %h exp 0", dut_vec()); errors++;
        end
        checks++;
    endtask

    task automatic test_random();
        logic b;
        logic [NC-1:0][1:0] e;
        b = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            e = '0;
            for (int c = 0; c < NC; c++) begin
                e[c][0] = ($urandom_range(0, 39) == 0);
                e[c][1] = $urandom_range(0, 1);
            end
            step($urandom_range(0, 3) == 0, e, b, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 49) == 0);
            if (dut_vec() !== mdl_vec()) begin
                $display("FAIL random cyc %0d got %h exp %h", i, dut_vec(), mdl_vec()); errors++;
            end
            checks++;
        end
        step(0, '0, 0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_ignored_events();
        test_saturation();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/redmule_job_monitor.md
REDMULE_JOB_MONITOR -- requirements
Module: redmule_job_monitor

Interface
REQ-001 SHALL have parameter N_CORES, default 8: number of event lanes from the accelerator wrapper.
REQ-002 SHALL have parameter CNT_W, default 32: width of the busy-cycle counter.
REQ-003 SHALL have parameter ARM_TIMEOUT, default 64: maximum cycles allowed between arm and busy rise.
REQ-004 SHALL have port clk_i, input, 1: clock.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1: single-cycle job launch request from the host.
REQ-007 SHALL have port evt_i, input, [N_CORES-1:0][1:0]: accelerator event lines.
REQ-008 SHALL have port busy_i, input, 1: accelerator busy flag.
REQ-009 SHALL have port irq_ack_i, input, 1: host acknowledge of the completion interrupt.
REQ-010 SHALL have port clear_i, input, 1: synchronous abort/clear.
REQ-011 SHALL have port fetch_enable_o, output, 1: drives the accelerator wrapper fetch_enable (clock-enable source).
REQ-012 SHALL have port irq_o, output, 1: job-complete interrupt, level.
REQ-013 SHALL have port err_o, output, 1: arm timeout flag, level.
REQ-014 SHALL have port busy_cycles_o, output, CNT_W: busy cycles of the current/last job.
REQ-015 SHALL have port job_count_o, output, 16: number of acknowledged jobs.

Function
REQ-016 SHALL implement the FSM states IDLE, ARM, RUN, DONE and ERR, all registered.
REQ-017 SHALL define done_evt as the OR over all cores c of evt_i[c][0]; evt_i[c][1] SHALL be ignored.
REQ-018 IDLE: when start_i=1, SHALL go to ARM, clear busy_cycles_o to 0 and reset the arm counter to 0; otherwise SHALL stay in IDLE.
REQ-019 ARM: SHALL increment the arm counter each cycle.
REQ-020 ARM: busy_i=1 SHALL move the FSM to RUN.
REQ-021 ARM: when the arm counter reaches ARM_TIMEOUT-1 with busy_i=0, SHALL go to ERR.
REQ-022 ARM: if busy_i=1 and the timeout condition occur in the same cycle, busy_i SHALL win and the FSM SHALL go to RUN.
REQ-023 RUN: busy_cycles_o SHALL increment on every cycle with busy_i=1 and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-024 RUN: done_evt=1 SHALL move the FSM to DONE; the cycle in which done_evt is sampled SHALL still be counted if busy_i=1.
REQ-025 DONE: irq_o SHALL be 1.
REQ-026 DONE: irq_ack_i=1 SHALL move the FSM to IDLE and increment job_count_o, with modulo-2^16 wrap.
REQ-027 DONE: start_i SHALL be ignored, including when asserted in the same cycle as irq_ack_i.
REQ-028 ERR: err_o SHALL be 1 and the FSM SHALL remain in ERR until clear_i=1.
REQ-029 fetch_enable_o SHALL be 1 exactly in ARM and RUN, and SHALL be a registered output derived from the next state, so it rises in the first ARM cycle.
REQ-030 done_evt outside RUN SHALL be ignored and SHALL NOT be latched.
REQ-031 start_i outside IDLE SHALL be ignored, with no queuing.
REQ-032 busy_i falling in RUN without done_evt SHALL keep the FSM in RUN and stop the counter.
REQ-033 clear_i=1 in any state SHALL force IDLE on the next edge, deassert fetch_enable_o, irq_o and err_o, and zero busy_cycles_o.
REQ-034 clear_i SHALL preserve job_count_o.
REQ-035 clear_i SHALL take priority over all other inputs.
REQ-036 busy_cycles_o SHALL hold its value in DONE and IDLE until the next start or clear.

Reset
REQ-037 While rst_ni=0, SHALL hold the FSM in IDLE, fetch_enable_o=0, irq_o=0, err_o=0, busy_cycles_o=0, job_count_o=0 and the arm counter at 0.
REQ-038 Reset mid-job SHALL abandon the job with no irq_o pulse.
REQ-039 All outputs SHALL be glitch-free register outputs.

Verification
REQ-040 SHALL cover nominal job: start pulse; busy_i high 3 cycles after arm for 10 cycles; evt_i[2][0] pulse in the last busy cycle -> fetch_enable_o high from ARM through RUN, busy_cycles_o=10, irq_o=1; after ack -> job_count_o=1, state IDLE.
REQ-041 SHALL cover arm timeout: ARM_TIMEOUT=4, start with busy_i held 0 -> err_o=1 after 4 ARM cycles, fetch_enable_o=0; clear_i -> IDLE with job_count_o unchanged.
REQ-042 SHALL cover ignored events: evt_i[0][0] pulses in IDLE and evt_i[5][1] pulses in RUN -> no state change, irq_o stays 0.
REQ-043 SHALL cover saturation: CNT_W=4, busy_i high for 20 RUN cycles -> busy_cycles_o=15.
REQ-044 SHALL cover simultaneous events: start_i and irq_ack_i together in DONE -> IDLE, job_count_o+1, no new ARM entry; clear_i with done_evt in RUN -> IDLE, irq_o=0.
REQ-045 SHALL cover async reset mid-RUN: rst_ni low for 1 cycle -> all outputs 0 immediately, job_count_o=0.
